// File: rtl/fp_dct_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// fp_dct_accumulator_pkg
// Shared definitions for the DCT product accumulator.
//  - Default packed FP format of the upstream multiplier (sign | exp | frac)
//    and the field positions derived from it.
//  - Exponent bias, largest finite exponent and the all-zero (+0) word.
//  - Encoding of the two accumulator FSM states.
// ---------------------------------------------------------------------------
package fp_dct_accumulator_pkg;

  localparam int FP_N = 23;
  localparam int FP_M = 8;
  localparam int FP_W = FP_N + FP_M + 1;

  localparam int SIGN_BIT = FP_N + FP_M;
  localparam int EXP_MSB  = FP_N + FP_M - 1;
  localparam int EXP_LSB  = FP_N;

  localparam int BIAS           = (1 << (FP_M - 1)) - 1;
  localparam int EXP_MAX_FINITE = (1 << FP_M) - 2;

  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } AccState_t;

endpackage

// File: rtl/fp_dct_accumulator_if.sv
// ---------------------------------------------------------------------------
// fp_dct_accumulator_if
// Product stream in, sum stream out, plus the group abort.
//  clear     : synchronous abort of the current group
//  in_valid  : product valid        in_ready  : accumulator accepts product
//  in_data   : product, packed FP
//  out_valid : sum valid            out_ready : consumer accepts sum
//  out_data  : sum, packed FP       out_ovf   : saturation seen in this group
// master = the side feeding products and consuming sums; slave = accumulator.
// ---------------------------------------------------------------------------
import fp_dct_accumulator_pkg::*;

interface fp_dct_accumulator_if #(
  parameter int N = FP_N,
  parameter int M = FP_M
);

  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [N+M:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N+M:0] out_data;
  logic         out_ovf;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/fp_dct_accumulator_fp_add.sv
// ---------------------------------------------------------------------------
// fp_add
// Combinational adder for the packed FP format (sign | M-bit exp | N-bit frac).
//  a, b : operands         sum : a + b, truncated toward zero
//  ovf  : result exponent saturated to the largest finite magnitude
// Zero-exponent operands are treated as signed zero; there is no inf/NaN.
// ---------------------------------------------------------------------------
import fp_dct_accumulator_pkg::*;

module fp_add #(
  parameter int N = FP_N,
  parameter int M = FP_M
) (
  input  logic [N+M:0] a,
  input  logic [N+M:0] b,
  output logic [N+M:0] sum,
  output logic         ovf
);

  // Hidden one, N fraction bits and guard/round/sticky.
  localparam int MW = N + 4;
  localparam logic [M-1:0] EXP_SAT = M'((1 << M) - 2);

  logic          bigSign;
  logic          sameSign;
  logic [M-1:0]  bigExp;
  logic [M-1:0]  smallExp;
  logic [N-1:0]  bigFrac;
  logic [N-1:0]  smallFrac;
  logic [MW-1:0] bigMan;
  logic [MW-1:0] smallMan;
  logic [MW-1:0] smallSh;
  logic [MW-1:0] normMan;
  logic [MW:0]   rawSum;
  logic          sticky;
  int            diff;
  int            lz;
  int            expVal;

  // Order the operands by magnitude so the subtraction never goes negative
  // and the result takes the sign of the larger operand.
  always_comb begin
    if (a[N+M-1:0] >= b[N+M-1:0]) begin
      bigSign   = a[N+M];
      bigExp    = a[N+M-1:N];
      bigFrac   = a[N-1:0];
      smallExp  = b[N+M-1:N];
      smallFrac = b[N-1:0];
    end else begin
      bigSign   = b[N+M];
      bigExp    = b[N+M-1:N];
      bigFrac   = b[N-1:0];
      smallExp  = a[N+M-1:N];
      smallFrac = a[N-1:0];
    end
    sameSign = (a[N+M] == b[N+M]);

    bigMan   = (bigExp   != '0) ? {1'b1, bigFrac,   3'b000} : '0;
    smallMan = (smallExp != '0) ? {1'b1, smallFrac, 3'b000} : '0;

    // Bits shifted past the guard positions collapse into the sticky bit so
    // a subtraction still borrows correctly before truncation.
    diff = int'(bigExp) - int'(smallExp);
    if (diff >= MW) begin
      smallSh = '0;
      sticky  = |smallMan;
    end else begin
      smallSh = smallMan >> diff;
      sticky  = |(smallMan & ~({MW{1'b1}} << diff));
    end
    smallSh[0] = smallSh[0] | sticky;

    rawSum = sameSign ? ({1'b0, bigMan} + {1'b0, smallSh})
                      : ({1'b0, bigMan} - {1'b0, smallSh});

    // Ascending scan: the last hit is the highest set bit.
    lz = 0;
    for (int i = 0; i < MW; i++) begin
      if (rawSum[i]) lz = MW - 1 - i;
    end

    expVal = int'(bigExp);
    if (rawSum[MW]) begin
      normMan = rawSum[MW:1];
      expVal  = expVal + 1;
    end else begin
      normMan = rawSum[MW-1:0] << lz;
      expVal  = expVal - lz;
    end

    sum = '0;
    ovf = 1'b0;
    if (rawSum == '0 || expVal < 1) begin
      sum = '0;
    end else if (expVal >= (1 << M) - 1) begin
      sum = {bigSign, EXP_SAT, {N{1'b1}}};
      ovf = 1'b1;
    end else begin
      sum = {bigSign, expVal[M-1:0], normMan[MW-2:3]};
    end
  end

endmodule

// File: rtl/fp_dct_accumulator.sv
// ---------------------------------------------------------------------------
// fp_dct_accumulator
// Sums LEN consecutive FP products and emits one FP sum per group.
//  clk : rising-edge clock
//  rst : asynchronous active-high reset
//  bus : slave side of fp_dct_accumulator_if (product in, sum out, clear)
// ACC accepts one product per cycle; after the LEN-th product the sum is
// held in HOLD until the consumer takes it.
// ---------------------------------------------------------------------------
import fp_dct_accumulator_pkg::*;

module fp_dct_accumulator #(
  parameter int N   = FP_N,
  parameter int M   = FP_M,
  parameter int LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  fp_dct_accumulator_if.slave    bus
);

  localparam int W  = N + M + 1;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  AccState_t       state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    outData_q, outData_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            outOvf_q, outOvf_d;
  logic            ovfSticky_q, ovfSticky_d;
  logic            readyEn_q;
  logic [W-1:0]    addSum;
  logic            addOvf;
  logic            beat;

  fp_add #(.N(N), .M(M)) u_fpAdd (
    .a  (acc_q),
    .b  (bus.in_data),
    .sum(addSum),
    .ovf(addOvf)
  );

  // readyEn_q keeps in_ready low until the first edge after reset releases.
  assign bus.in_ready  = readyEn_q && (state_q == ACC);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = outData_q;
  assign bus.out_ovf   = outOvf_q;
  assign beat          = bus.in_valid && bus.in_ready;

  // Next-state logic; clear overrides both beats and a pending handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    outData_d   = outData_q;
    outOvf_d    = outOvf_q;
    ovfSticky_d = ovfSticky_q;

    if (bus.clear) begin
      state_d     = ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovfSticky_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (beat) begin
            ovfSticky_d = ovfSticky_q | addOvf;
            if (cnt_q == LAST) begin
              outData_d = addSum;
              outOvf_d  = ovfSticky_q | addOvf;
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = HOLD;
            end else begin
              acc_d = addSum;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            ovfSticky_d = 1'b0;
            state_d     = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      outData_q   <= '0;
      outOvf_q    <= 1'b0;
      ovfSticky_q <= 1'b0;
      readyEn_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      outData_q   <= outData_d;
      outOvf_q    <= outOvf_d;
      ovfSticky_q <= ovfSticky_d;
      readyEn_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_dct_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fp_dct_accumulator
// Self-checking bench for fp_dct_accumulator (N=23, M=8, LEN=8).
// Expected sums are queued when a group is driven and compared when the
// accumulator hands the sum over.
// ---------------------------------------------------------------------------
module tb_fp_dct_accumulator;

  localparam logic [31:0] ONE     = 32'h3F800000;
  localparam logic [31:0] TWO     = 32'h40000000;
  localparam logic [31:0] EIGHT   = 32'h41000000;
  localparam logic [31:0] SIXTEEN = 32'h41800000;

  typedef struct packed {
    logic [7:0][31:0] beats;
    logic [31:0]      expSum;
    logic             expOvf;
  } Vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } Exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  Exp_t sbQ[$];
  Vec_t vecs[12];

  always #5 clk = ~clk;

  fp_dct_accumulator_if #(.N(23), .M(8)) bus ();

  fp_dct_accumulator #(.N(23), .M(8), .LEN(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every completed handshake must match the oldest queued sum.
  always @(negedge clk) begin : monitor
    Exp_t e;
    if (!rst && bus.out_valid && bus.out_ready && !bus.clear) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedSum", bus.out_data, 32'hxxxxxxxx);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sumData", bus.out_data, e.data);
        checkOutput("sumOvf", {31'b0, bus.out_ovf}, {31'b0, e.ovf});
      end
    end
  end

  // Presents one product and returns one cycle after it was taken.
  task automatic sendBeat(input logic [31:0] d);
    int waitCnt = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    while (!bus.in_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.in_ready) checkOutput("beatTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0][31:0] beats, input logic push,
                               input logic [31:0] expSum, input logic expOvf);
    if (push) sbQ.push_back('{data: expSum, ovf: expOvf});
    for (int i = 0; i < 8; i++) sendBeat(beats[i]);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sbQ.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sbQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{beats: {8{ONE}}, expSum: EIGHT, expOvf: 1'b0};
    vecs[1]  = '{beats: {4{32'hBF800000, ONE}}, expSum: 32'h0, expOvf: 1'b0};
    vecs[2]  = '{beats: {{7{32'h3F000000}}, 32'h40400000}, expSum: 32'h40D00000, expOvf: 1'b0};
    vecs[3]  = '{beats: {8{32'h7F7FFFFF}}, expSum: 32'h7F7FFFFF, expOvf: 1'b1};
    vecs[4]  = '{beats: {8{ONE}}, expSum: EIGHT, expOvf: 1'b0};
    vecs[5]  = '{beats: {8{32'hC0000000}}, expSum: 32'hC1800000, expOvf: 1'b0};
    vecs[6]  = '{beats: {8{32'h3FC00000}}, expSum: 32'h41400000, expOvf: 1'b0};
    vecs[7]  = '{beats: {{7{32'h33800000}}, ONE}, expSum: ONE, expOvf: 1'b0};
    vecs[8]  = '{beats: {{6{32'h0}}, 32'hB3800000, ONE}, expSum: 32'h3F7FFFFF, expOvf: 1'b0};
    vecs[9]  = '{beats: {{6{32'h0}}, 32'h80800000, 32'h00C00000}, expSum: 32'h0, expOvf: 1'b0};
    vecs[10] = '{beats: {ONE, {7{32'h00400000}}}, expSum: ONE, expOvf: 1'b0};
    vecs[11] = '{beats: {8{32'hFF7FFFFF}}, expSum: 32'hFF7FFFFF, expOvf: 1'b1};

    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    #2;
    checkOutput("rstOutValid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rstOutData", bus.out_data, 32'd0);
    checkOutput("rstOutOvf", {31'b0, bus.out_ovf}, 32'd0);
    checkOutput("rstInReady", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("inReadyBeforeEdge", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("inReadyAfterEdge", {31'b0, bus.in_ready}, 32'd1);

    // Latency: out_valid rises the cycle after the eighth beat.
    sbQ.push_back('{data: EIGHT, ovf: 1'b0});
    for (int i = 0; i < 8; i++) begin
      sendBeat(ONE);
      if (i == 6) checkOutput("validAfterBeat7", {31'b0, bus.out_valid}, 32'd0);
    end
    checkOutput("validAfterBeat8", {31'b0, bus.out_valid}, 32'd1);
    checkOutput("inReadyInHold", {31'b0, bus.in_ready}, 32'd0);
    waitDrain();

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].beats, 1'b1, vecs[v].expSum, vecs[v].expOvf);
      waitDrain();
    end

    // Back-pressure: sum held, extra products refused.
    bus.out_ready = 1'b0;
    applyStimulus({8{ONE}}, 1'b1, EIGHT, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = ONE;
      @(negedge clk);
      checkOutput("holdValid", {31'b0, bus.out_valid}, 32'd1);
      checkOutput("holdData", bus.out_data, EIGHT);
      checkOutput("holdInReady", {31'b0, bus.in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    waitDrain();
    applyStimulus({8{ONE}}, 1'b1, EIGHT, 1'b0);
    waitDrain();

    // Clear together with the fourth beat aborts the group.
    for (int i = 0; i < 3; i++) sendBeat(ONE);
    bus.in_valid = 1'b1;
    bus.in_data  = ONE;
    bus.clear    = 1'b1;
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    applyStimulus({8{TWO}}, 1'b1, SIXTEEN, 1'b0);
    waitDrain();

    // Clear while holding drops the sum even with out_ready high.
    bus.out_ready = 1'b0;
    applyStimulus({8{ONE}}, 1'b0, EIGHT, 1'b0);
    checkOutput("holdBeforeClear", {31'b0, bus.out_valid}, 32'd1);
    bus.clear     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    checkOutput("validAfterClear", {31'b0, bus.out_valid}, 32'd0);
    applyStimulus({8{TWO}}, 1'b1, SIXTEEN, 1'b0);
    waitDrain();

    // Asynchronous reset between edges in the middle of a group.
    for (int i = 0; i < 3; i++) sendBeat(ONE);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstValid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("asyncRstData", bus.out_data, 32'd0);
    checkOutput("asyncRstCnt", 32'(dut.cnt_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus({8{ONE}}, 1'b1, EIGHT, 1'b0);
    waitDrain();

    checkOutput("queueEmpty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
